// File: rtl/seq_pkg.sv
// Shared types and sizes for the program-counter sequencer and its jump table.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    MEM_WAIT,
    HALT
  } seq_state_t;

  localparam int JPTR_W    = 5;
  localparam int LUT_DEPTH = 32;

endpackage

// File: rtl/jump_lut.sv
// Jump-target table: 32 programmable PC targets, one synchronous write port,
// one combinational read port, synchronous active-low clear.
module jump_lut
  import seq_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [JPTR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [JPTR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [LUT_DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: steps the PC from decoder outputs, stalls for
// fixed-latency memory ops, resolves jumps through the jump table.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [PC_W-1:0]   Start_addr,
  input  logic              Jen,
  input  logic [JPTR_W-1:0] Jptr,
  input  logic              Done,
  input  logic              Load,
  input  logic              Store,
  input  logic              Lut_we,
  input  logic [JPTR_W-1:0] Lut_addr,
  input  logic [PC_W-1:0]   Lut_data,
  output logic [PC_W-1:0]   Prog_ctr,
  output logic              Instr_valid,
  output logic              Stall,
  output logic              Mem_commit,
  output logic              Ack,
  output logic [CNT_W-1:0]  Instr_cnt
);

  localparam int WAIT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  seq_state_t        state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [PC_W-1:0]   lut_target;
  logic              advance;
  logic              stall_c;
  logic              commit_c;
  logic              mem_op;

  assign mem_op = Load | Store;

  // Table is only writable while no program runs, so a jump never races a rewrite.
  jump_lut #(
    .DATA_W(PC_W)
  ) u_jump_lut (
    .clk_i   (Clk),
    .rst_ni  (Reset),
    .we_i    (Lut_we && (state_q == IDLE)),
    .waddr_i (Lut_addr),
    .wdata_i (Lut_data),
    .raddr_i (Jptr),
    .rdata_o (lut_target)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    advance  = 1'b0;
    stall_c  = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = Start_addr;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (Done) begin
          state_d = HALT;
        end else if (mem_op) begin
          if (MEM_LAT > 0) begin
            state_d = MEM_WAIT;
            wait_d  = WAIT_W'(MEM_LAT - 1);
            stall_c = 1'b1;
          end else begin
            commit_c = 1'b1;
            advance  = 1'b1;
            pc_d     = pc_q + PC_W'(1);
          end
        end else if (Jen) begin
          advance = 1'b1;
          pc_d    = lut_target;
        end else begin
          advance = 1'b1;
          pc_d    = pc_q + PC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (wait_q == '0) begin
          state_d  = RUN;
          commit_c = 1'b1;
          advance  = 1'b1;
          pc_d     = pc_q + PC_W'(1);
        end else begin
          stall_c = 1'b1;
          wait_d  = wait_q - WAIT_W'(1);
        end
      end
      HALT: begin
        if (!Start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Retired count sticks at all-ones rather than wrapping.
    if (advance && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  assign Prog_ctr    = pc_q;
  assign Instr_cnt   = cnt_q;
  assign Instr_valid = (state_q == RUN) || (state_q == MEM_WAIT);
  assign Ack         = (state_q == HALT);
  assign Stall       = stall_c;
  assign Mem_commit  = commit_c;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each step drives decoder inputs, queues the
// outputs expected for that cycle, then pops and checks them mid-cycle.
module tb_pc_sequencer;

  localparam int PC_W    = 10;
  localparam int MEM_LAT = 2;
  localparam int CNT_W   = 16;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic [PC_W-1:0]  Start_addr;
  logic             Jen;
  logic [4:0]       Jptr;
  logic             Done;
  logic             Load;
  logic             Store;
  logic             Lut_we;
  logic [4:0]       Lut_addr;
  logic [PC_W-1:0]  Lut_data;
  logic [PC_W-1:0]  Prog_ctr;
  logic             Instr_valid;
  logic             Stall;
  logic             Mem_commit;
  logic             Ack;
  logic [CNT_W-1:0] Instr_cnt;

  typedef struct {
    string            tag;
    logic [PC_W-1:0]  pc;
    logic             valid;
    logic             stall;
    logic             commit;
    logic             ack;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t scoreboard[$];
  int   assertCount = 0;
  int   failCount   = 0;

  pc_sequencer #(
    .PC_W    (PC_W),
    .MEM_LAT (MEM_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Start_addr  (Start_addr),
    .Jen         (Jen),
    .Jptr        (Jptr),
    .Done        (Done),
    .Load        (Load),
    .Store       (Store),
    .Lut_we      (Lut_we),
    .Lut_addr    (Lut_addr),
    .Lut_data    (Lut_data),
    .Prog_ctr    (Prog_ctr),
    .Instr_valid (Instr_valid),
    .Stall       (Stall),
    .Mem_commit  (Mem_commit),
    .Ack         (Ack),
    .Instr_cnt   (Instr_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s.%s observed %0h expected %0h", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (scoreboard.size() == 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard observed empty expected entry");
    end else begin
      e = scoreboard.pop_front();
      checkField(e.tag, "pc",     32'(Prog_ctr),    32'(e.pc));
      checkField(e.tag, "valid",  32'(Instr_valid), 32'(e.valid));
      checkField(e.tag, "stall",  32'(Stall),       32'(e.stall));
      checkField(e.tag, "commit", 32'(Mem_commit),  32'(e.commit));
      checkField(e.tag, "ack",    32'(Ack),         32'(e.ack));
      checkField(e.tag, "cnt",    32'(Instr_cnt),   32'(e.cnt));
    end
  endtask

  // Called at posedge+2; checks at posedge+4, returns at the next posedge+2.
  task automatic applyStimulus(input string tag, input logic st, input logic [PC_W-1:0] addr,
                               input logic jen, input logic [4:0] jptr, input logic done,
                               input logic ld, input logic sr,
                               input logic [PC_W-1:0] ePc, input logic eValid,
                               input logic eStall, input logic eCommit, input logic eAck,
                               input logic [CNT_W-1:0] eCnt);
    exp_t e;
    Start      = st;
    Start_addr = addr;
    Jen        = jen;
    Jptr       = jptr;
    Done       = done;
    Load       = ld;
    Store      = sr;
    e.tag    = tag;
    e.pc     = ePc;
    e.valid  = eValid;
    e.stall  = eStall;
    e.commit = eCommit;
    e.ack    = eAck;
    e.cnt    = eCnt;
    scoreboard.push_back(e);
    #2;
    checkOutput();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; Start_addr = '0; Jen = 1'b0; Jptr = '0;
    Done = 1'b0; Load = 1'b0; Store = 1'b0;
    Lut_we = 1'b0; Lut_addr = '0; Lut_data = '0;
    @(posedge Clk);
    #2;
    applyStimulus("reset", 0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    Reset = 1'b1;

    // Reset while stalled on a load.
    applyStimulus("a_start",  1, 10'h005, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    applyStimulus("a_load",   1, 10'h005, 0, 0, 0, 1, 0, 10'h005, 1, 1, 0, 0, 0);
    Reset = 1'b0;
    applyStimulus("a_wait",   1, 10'h005, 0, 0, 0, 0, 0, 10'h005, 1, 1, 0, 0, 0);
    Reset = 1'b1;
    applyStimulus("a_rst",    0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    applyStimulus("a_start2", 1, 10'h050, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 0);
    applyStimulus("a_jmp0",   1, 10'h050, 1, 3, 0, 0, 0, 10'h050, 1, 0, 0, 0, 0);
    applyStimulus("a_done",   1, 10'h050, 0, 0, 1, 0, 0, 10'h000, 1, 0, 0, 0, 1);
    applyStimulus("a_halt",   0, 10'h050, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 1, 1);

    // Table write coinciding with start, then jump and a write attempt in RUN.
    Lut_we = 1'b1; Lut_addr = 5'd3; Lut_data = 10'h040;
    applyStimulus("b_wr_start", 1, 10'h010, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 1);
    Lut_we = 1'b0;
    applyStimulus("b_pc10",  1, 10'h010, 0, 0, 0, 0, 0, 10'h010, 1, 0, 0, 0, 0);
    applyStimulus("b_pc11",  0, 10'h010, 0, 0, 0, 0, 0, 10'h011, 1, 0, 0, 0, 1);
    applyStimulus("b_pc12",  0, 10'h010, 1, 3, 0, 0, 0, 10'h012, 1, 0, 0, 0, 2);
    Lut_we = 1'b1; Lut_addr = 5'd3; Lut_data = 10'h111;
    applyStimulus("b_pc40",  0, 10'h010, 0, 0, 0, 0, 0, 10'h040, 1, 0, 0, 0, 3);
    Lut_we = 1'b0;
    applyStimulus("b_pc41",  0, 10'h010, 1, 3, 0, 0, 0, 10'h041, 1, 0, 0, 0, 4);
    applyStimulus("b_pc40b", 0, 10'h010, 0, 0, 1, 0, 0, 10'h040, 1, 0, 0, 0, 5);
    applyStimulus("b_halt",  0, 10'h010, 0, 0, 0, 0, 0, 10'h040, 0, 0, 0, 1, 5);
    applyStimulus("b_idle",  0, 10'h010, 0, 0, 0, 0, 0, 10'h040, 0, 0, 0, 0, 5);

    // Load stall timing, then Done beating a Store, halt handshake and restart.
    applyStimulus("c_start",     1, 10'h020, 0, 0, 0, 0, 0, 10'h040, 0, 0, 0, 0, 5);
    applyStimulus("c_load",      1, 10'h020, 0, 0, 0, 1, 0, 10'h020, 1, 1, 0, 0, 0);
    applyStimulus("c_wait1",     1, 10'h020, 0, 0, 0, 0, 0, 10'h020, 1, 1, 0, 0, 0);
    applyStimulus("c_wait0",     1, 10'h020, 0, 0, 0, 0, 0, 10'h020, 1, 0, 1, 0, 0);
    applyStimulus("c_done_st",   1, 10'h020, 0, 0, 1, 0, 1, 10'h021, 1, 0, 0, 0, 1);
    applyStimulus("c_halt_hold", 1, 10'h020, 0, 0, 0, 0, 0, 10'h021, 0, 0, 0, 1, 1);
    applyStimulus("c_halt_drop", 0, 10'h020, 0, 0, 0, 0, 0, 10'h021, 0, 0, 0, 1, 1);
    applyStimulus("c_idle",      1, 10'h030, 0, 0, 0, 0, 0, 10'h021, 0, 0, 0, 0, 1);
    applyStimulus("c_pc30",      1, 10'h030, 0, 0, 1, 0, 0, 10'h030, 1, 0, 0, 0, 0);
    applyStimulus("c_halt2",     0, 10'h030, 0, 0, 0, 0, 0, 10'h030, 0, 0, 0, 1, 0);

    // PC wrap from the top of the address space.
    applyStimulus("d_start", 1, 10'h3FE, 0, 0, 0, 0, 0, 10'h030, 0, 0, 0, 0, 0);
    applyStimulus("d_3fe",   1, 10'h3FE, 0, 0, 0, 0, 0, 10'h3FE, 1, 0, 0, 0, 0);
    applyStimulus("d_3ff",   1, 10'h3FE, 0, 0, 0, 0, 0, 10'h3FF, 1, 0, 0, 0, 1);
    applyStimulus("d_000",   1, 10'h3FE, 0, 0, 1, 0, 0, 10'h000, 1, 0, 0, 0, 2);
    applyStimulus("d_halt",  0, 10'h3FE, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 1, 2);
    applyStimulus("d_idle",  0, 10'h3FE, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer and fetch controller for the 9-bit core. Owns the program counter, steps it each cycle from the decoder's `Jen`/`Jptr`/`Done`/`Load`/`Store` outputs, inserts fixed-latency stall cycles for data-memory operations, and resolves 5-bit jump pointers through a programmable target table. It sits between the testbench/top-level start handshake and the instruction ROM, which is read combinationally at `Prog_ctr`.

## Interface
- `PC_W`, 10: program counter width.
- `MEM_LAT`, 2: extra cycles per load/store (0 = no stall).
- `CNT_W`, 16: retired-instruction counter width.
- `Clk  in  1`: clock; all state updates on the rising edge.
- `Reset  in  1`: synchronous, active-low reset.
- `Start  in  1`: level request to run a program; held until `Ack`.
- `Start_addr  in  PC_W`: first PC, sampled on IDLE→RUN.
- `Jen  in  1`: decoded taken branch.
- `Jptr  in  5`: jump-table index.
- `Done  in  1`: decoded halt.
- `Load`, `Store`  in  1 each: decoded memory op.
- `Lut_we  in  1`, `Lut_addr  in  5`, `Lut_data  in  PC_W`: jump-table write port.
- `Prog_ctr  out  PC_W`: current PC (registered).
- `Instr_valid  out  1`: current instruction is executing; datapath enables are qualified by this.
- `Stall  out  1`: datapath must hold; instruction at `Prog_ctr` unchanged.
- `Mem_commit  out  1`: one-cycle pulse on the final cycle of a memory op.
- `Ack  out  1`: program halted.
- `Instr_cnt  out  CNT_W`: retired instructions.

## Operation
- States: IDLE, RUN, MEM_WAIT, HALT.
- IDLE: `Instr_valid=0`. If `Start=1`: `Prog_ctr<=Start_addr`, `Instr_cnt<=0`, → RUN. `Lut_we` is honoured only in IDLE; otherwise ignored.
- RUN: `Instr_valid=1`. Priority, highest first:
  - `Done` → HALT, PC held, not counted as retired.
  - `Load|Store`, `MEM_LAT>0` → MEM_WAIT, wait counter `<=MEM_LAT-1`, PC held.
  - `Load|Store`, `MEM_LAT=0` → `Mem_commit=1`, PC+1.
  - `Jen` → `Prog_ctr<=lut[Jptr]`.
  - Otherwise PC+1.
- MEM_WAIT: `Instr_valid=1`, `Stall=1` (except final cycle). Counter decrements. At 0: `Stall=0`, `Mem_commit=1`, PC+1, → RUN.
- HALT: `Ack=1`, PC held. `Start=0` → IDLE, after which `Ack=0`.
- Increment wraps modulo 2^PC_W: 2^PC_W−1 → 0.
- `Instr_cnt` increments on each PC advance (increment, jump, or memory completion) and saturates at all-ones.
- Jump table: 32×PC_W registers, reset to 0. A write in the same cycle as IDLE→RUN completes, and the new value is visible to the first jump.

## Timing
- Reset (`Reset=0` at an edge, from any state): IDLE, `Prog_ctr=0`, `Instr_cnt=0`, all table entries 0. `Instr_valid`, `Stall`, `Mem_commit` and `Ack` are all 0.
- `Start` sampled high in IDLE: first instruction is valid on the next cycle.
- Non-memory instruction: 1 cycle. Memory instruction: 1+`MEM_LAT` cycles.
- Jump: target is at `Prog_ctr` the cycle after `Jen`; no delay slot.
- `Ack` rises the cycle after `Done` is decoded. `Start` dropping in HALT clears `Ack` one cycle later.
- `Start` deasserted early in RUN or MEM_WAIT: ignored; the program runs to `Done`.
- `Done` with `Load`/`Store` in the same cycle: `Done` wins, and no `Mem_commit` is issued.

## Structure
- Package `seq_pkg`: state enum `seq_state_t` {IDLE, RUN, MEM_WAIT, HALT}, `JPTR_W=5`, `LUT_DEPTH=32`.
- Sub-module `jump_lut`: 32-entry register file with one synchronous write port, one combinational read port, and synchronous active-low clear.
- The FSM, PC register, wait counter and instruction counter live in `pc_sequencer`.

## Test plan
- Reset mid-MEM_WAIT (`Prog_ctr=0x05`) → next cycle IDLE, `Prog_ctr=0`, `Stall=0`, table entry 3 reads 0.
- Program table[3]=0x040 in IDLE. `Start_addr=0x010`. `Jen=1`, `Jptr=3` at PC 0x012 → PC sequence 0x010, 0x011, 0x012, 0x040. `Instr_cnt=3`.
- `MEM_LAT=2`, `Load` at PC 0x020 → `Stall` high 2 cycles, `Mem_commit` on the 3rd cycle, PC 0x021 on the 4th.
- `Done` at PC 0x030 → `Ack=1` the next cycle and PC stays 0x030. Drop `Start` → `Ack=0` one cycle after the IDLE transition. Re-raise `Start` → program restarts.
- `Start_addr=0x3FF`, `PC_W=10`, no jumps → PC wraps 0x3FF → 0x000.
- `Lut_we` pulsed in RUN (addr 3, data 0x111) → entry 3 unchanged, and a later jump via 3 goes to the old target.
